// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
//   pll_state_e : supervisor FSM states (3-bit encoding)
//   RETRY_W     : width of the failed-attempt counter
//   LOSS_W      : width of the lock-loss counter
//   LOSS_MAX    : saturation value of the lock-loss counter
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RST    = 3'd0,
      WAIT   = 3'd1,
      STABLE = 3'd2,
      RUN    = 3'd3,
      FAIL   = 3'd4
   } pll_state_e;

   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;
   localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
//   clk_i  : destination clock
//   rst_ni : synchronous active-low reset, clears both flops to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output, 2 edges of latency
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor, clocked by the PLL reference clock.
// Sequences the PLL reset, waits for lock, qualifies it over a stability
// window, then releases the USB-domain reset. Counts failed attempts, enters
// FAIL after MAX_RETRY of them, and counts lock losses from RUN.
//   refclk        : reference clock (sole clock)
//   rst_n         : synchronous active-low reset
//   pll_locked    : PLL lock, asynchronous to refclk
//   retry_req     : pulse, restarts sequencing from FAIL only
//   pll_rst       : PLL reset, active-high
//   usb_rst_n     : USB-domain reset, active-low
//   ready         : high in RUN
//   fail          : high in FAIL
//   lock_loss     : one-cycle pulse when lock is lost from RUN
//   retry_cnt     : failed attempts in the current sequence
//   lock_loss_cnt : lock losses since reset, saturating
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_CYCLES    = 20,
   parameter int LOCK_TIMEOUT  = 20000,
   parameter int STABLE_CYCLES = 200,
   parameter int MAX_RETRY     = 8,
   parameter int CNT_W         = 16
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic              pll_locked,
   input  logic              retry_req,
   output logic              pll_rst,
   output logic              usb_rst_n,
   output logic              ready,
   output logic              fail,
   output logic              lock_loss,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  lock_loss_cnt
);

   localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

   logic lk_s;

   sync_2ff u_lock_sync (
      .clk_i  (refclk),
      .rst_ni (rst_n),
      .d_i    (pll_locked),
      .q_o    (lk_s)
   );

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
   logic [LOSS_W-1:0]  loss_cnt_q, loss_cnt_d;
   logic               lock_loss_q, lock_loss_d;
   logic               pll_rst_q, usb_rst_n_q, ready_q, fail_q;
   logic               attempt_fail;

   always_comb begin
      state_d      = state_q;
      cnt_inc      = cnt_q + CNT_W'(1);
      cnt_d        = cnt_q;
      retry_inc    = retry_q + RETRY_W'(1);
      retry_d      = retry_q;
      loss_cnt_d   = loss_cnt_q;
      lock_loss_d  = 1'b0;
      attempt_fail = 1'b0;

      case (state_q)
         RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT: begin
            // Lock seen wins over a timeout landing on the same cycle.
            if (lk_s) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               attempt_fail = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         STABLE: begin
            // The WAIT cycle that saw lock is the first qualified cycle, so the
            // window closes when the incremented count reaches STABLE_CYCLES-1.
            if (!lk_s) begin
               attempt_fail = 1'b1;
            end else if (cnt_inc >= ST_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
               retry_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RUN: begin
            if (!lk_s) begin
               state_d     = RST;
               cnt_d       = '0;
               lock_loss_d = 1'b1;
               if (loss_cnt_q != LOSS_MAX) loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            end
         end
         FAIL: begin
            if (retry_req) begin
               state_d = RST;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = RST;
            cnt_d   = '0;
         end
      endcase

      if (attempt_fail) begin
         retry_d = retry_inc;
         state_d = (retry_inc == RETRY_LIM) ? FAIL : RST;
         cnt_d   = '0;
      end
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as the state register.
   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         state_q     <= RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         loss_cnt_q  <= '0;
         lock_loss_q <= 1'b0;
         pll_rst_q   <= 1'b1;
         usb_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_cnt_q  <= loss_cnt_d;
         lock_loss_q <= lock_loss_d;
         pll_rst_q   <= (state_d == RST) || (state_d == FAIL);
         usb_rst_n_q <= (state_d == RUN);
         ready_q     <= (state_d == RUN);
         fail_q      <= (state_d == FAIL);
      end
   end

   assign pll_rst       = pll_rst_q;
   assign usb_rst_n     = usb_rst_n_q;
   assign ready         = ready_q;
   assign fail          = fail_q;
   assign lock_loss     = lock_loss_q;
   assign retry_cnt     = retry_q;
   assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboarded bench for pll_lock_supervisor. Each scenario pushes expected
// output vectors tagged with the edge they belong to, then clocks the DUT and
// pops/compares them as those edges occur.
// Vector layout: {pll_rst, usb_rst_n, ready, fail, lock_loss, retry_cnt, lock_loss_cnt}
module tb_pll_lock_supervisor;

   logic       refclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic       retry_req = 1'b0;
   logic       pll_rst, usb_rst_n, ready, fail, lock_loss;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   pll_lock_supervisor #(
      .RST_CYCLES    (4),
      .LOCK_TIMEOUT  (16),
      .STABLE_CYCLES (4),
      .MAX_RETRY     (3),
      .CNT_W         (16)
   ) dut (
      .refclk        (refclk),
      .rst_n         (rst_n),
      .pll_locked    (pll_locked),
      .retry_req     (retry_req),
      .pll_rst       (pll_rst),
      .usb_rst_n     (usb_rst_n),
      .ready         (ready),
      .fail          (fail),
      .lock_loss     (lock_loss),
      .retry_cnt     (retry_cnt),
      .lock_loss_cnt (lock_loss_cnt)
   );

   always #25 refclk = ~refclk;

   int cyc = 0;
   always @(posedge refclk) cyc <= cyc + 1;

   logic [16:0] obs;
   assign obs = {pll_rst, usb_rst_n, ready, fail, lock_loss, retry_cnt, lock_loss_cnt};

   typedef struct {
      int          cyc;
      logic [16:0] v;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   base;
   int   checks = 0;
   int   errors = 0;

   function automatic logic [16:0] ov(bit pr, bit un, bit rd, bit fl, bit ll,
                                      logic [3:0] rc, logic [7:0] lc);
      return {pr, un, rd, fl, ll, rc, lc};
   endfunction

   task automatic exp_at(int t, logic [16:0] v, string tag);
      exp_t x;
      x.cyc = base + t;
      x.v   = v;
      x.tag = tag;
      sb.push_back(x);
   endtask

   // Reset, then lock 5 cycles after pll_rst falls.
   task automatic test_reset();
      base = cyc;
      for (int t = 1; t <= 6; t++) exp_at(t, ov(1,0,0,0,0,0,0), "reset_prst");
      exp_at(7,  ov(0,0,0,0,0,0,0), "prst_fall");
      exp_at(16, ov(0,0,0,0,0,0,0), "pre_run");
      exp_at(17, ov(0,1,1,0,0,0,0), "run_entry");
      exp_at(18, ov(0,1,1,0,0,0,0), "run_hold");
      for (int t = 1; t <= 18; t++) begin
         rst_n      = (t > 3);
         pll_locked = (t >= 12);
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_reset pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   // Lock never arrives: three timeouts then FAIL.
   task automatic test_timeout();
      base = cyc;
      exp_at(1,  ov(1,0,0,0,0,0,0), "to_reset");
      exp_at(4,  ov(1,0,0,0,0,0,0), "to_rst_end");
      exp_at(5,  ov(0,0,0,0,0,0,0), "to_wait1");
      exp_at(20, ov(0,0,0,0,0,0,0), "to_wait1_end");
      exp_at(21, ov(1,0,0,0,0,1,0), "to_retry1");
      exp_at(25, ov(0,0,0,0,0,1,0), "to_wait2");
      exp_at(41, ov(1,0,0,0,0,2,0), "to_retry2");
      exp_at(45, ov(0,0,0,0,0,2,0), "to_wait3");
      exp_at(60, ov(0,0,0,0,0,2,0), "to_wait3_end");
      exp_at(61, ov(1,0,0,1,0,3,0), "to_fail");
      exp_at(70, ov(1,0,0,1,0,3,0), "to_fail_hold");
      for (int t = 1; t <= 70; t++) begin
         rst_n      = (t > 1);
         pll_locked = 1'b0;
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_timeout pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   // retry_req out of FAIL, lock, then retry_req in RUN is ignored.
   task automatic test_retry_req();
      base = cyc;
      exp_at(1,  ov(1,0,0,0,0,0,0), "rq_leave_fail");
      exp_at(5,  ov(0,0,0,0,0,0,0), "rq_wait");
      exp_at(8,  ov(0,0,0,0,0,0,0), "rq_stable");
      exp_at(9,  ov(0,1,1,0,0,0,0), "rq_run");
      exp_at(12, ov(0,1,1,0,0,0,0), "rq_ignored");
      exp_at(14, ov(0,1,1,0,0,0,0), "rq_ignored2");
      for (int t = 1; t <= 14; t++) begin
         pll_locked = 1'b1;
         retry_req  = (t == 1) || (t == 12);
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      retry_req = 1'b0;
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_retry_req pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   // One-cycle lock glitch during STABLE costs one attempt.
   task automatic test_stable_drop();
      base = cyc;
      exp_at(1,  ov(1,0,0,0,0,0,0), "sd_reset");
      exp_at(8,  ov(0,0,0,0,0,0,0), "sd_stable");
      exp_at(10, ov(0,0,0,0,0,0,0), "sd_stable2");
      exp_at(11, ov(1,0,0,0,0,1,0), "sd_retry");
      exp_at(15, ov(0,0,0,0,0,1,0), "sd_wait");
      exp_at(18, ov(0,0,0,0,0,1,0), "sd_stable3");
      exp_at(19, ov(0,1,1,0,0,0,0), "sd_run");
      for (int t = 1; t <= 19; t++) begin
         rst_n      = (t > 1);
         pll_locked = (t >= 6) && (t != 9);
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_stable_drop pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   // 260 lock losses from RUN; counter saturates at 255.
   task automatic test_lock_loss();
      int lc;
      base = cyc;
      for (int n = 0; n < 260; n++) begin
         lc = (n + 1 > 255) ? 255 : n + 1;
         exp_at(2 + 12*n, ov(0,1,1,0,0,0,8'((n > 255) ? 255 : n)), "ll_still_run");
         exp_at(3 + 12*n, ov(1,0,0,0,1,0,8'(lc)), "ll_pulse");
         exp_at(4 + 12*n, ov(1,0,0,0,0,0,8'(lc)), "ll_pulse_end");
      end
      exp_at(12*260, ov(0,1,1,0,0,0,8'd255), "ll_final_run");
      for (int t = 1; t <= 12*260; t++) begin
         pll_locked = ((t - 1) % 12) > 2;
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_lock_loss pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   // Reset during RUN: everything clears, no lock_loss pulse.
   task automatic test_reset_in_run();
      base = cyc;
      exp_at(1, ov(1,0,0,0,0,0,0), "rr_reset");
      exp_at(2, ov(1,0,0,0,0,0,0), "rr_no_pulse");
      exp_at(5, ov(0,0,0,0,0,0,0), "rr_wait");
      exp_at(9, ov(0,1,1,0,0,0,0), "rr_run");
      for (int t = 1; t <= 9; t++) begin
         rst_n      = (t > 1);
         pll_locked = 1'b1;
         @(posedge refclk); #1;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin
               errors++;
               $display("FAIL %s t=%0d got=%h want=%h", e.tag, t, obs, e.v);
            end
         end
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL test_reset_in_run pending=%0d want=0", sb.size()); sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_timeout();
      test_retry_req();
      test_stable_drop();
      test_lock_loss();
      test_reset_in_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
